// File: rtl/unified_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : unified_mem_arbiter
//  Purpose  : Shares one fixed-latency unified memory between the IF-stage
//             fetch port and the MEM-stage data port. Accesses are
//             serialised, each port gets a one-cycle ack with its read data,
//             and busy tells the stall logic that an access is outstanding.
//  Options  : ARB_FETCH_BUF_EN - single-entry fetch buffer that answers a
//             repeated fetch of the last fetched address without memory.
//  Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
   parameter int LATENCY = 4,   // mem_en cycle to mem_rdata valid, 1..15
   parameter int AW      = 16,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   // fetch port
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   // data port
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   // memory side
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   // status
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      INST = 2'd2
   } state_t;

   localparam logic [3:0] LAT_LOAD   = 4'(LATENCY);
   localparam logic       GRANT_INST = 1'b0;
   localparam logic       GRANT_DATA = 1'b1;

   state_t        state, state_nx;
   logic [3:0]    cnt, cnt_nx;
   logic          last_grant, last_grant_nx;
   logic [DW-1:0] if_rdata_nx, d_rdata_nx, mem_wdata_nx;
   logic [AW-1:0] mem_addr_nx;
   logic          if_ack_nx, d_ack_nx, mem_en_nx, mem_we_nx, busy_nx;

   logic          d_elig, if_elig, buf_hit, if_to_mem, grant_d, grant_i;

`ifdef ARB_FETCH_BUF_EN
   logic          buf_valid, buf_valid_nx;
   logic [AW-1:0] buf_addr, buf_addr_nx;
   logic [DW-1:0] buf_data, buf_data_nx;
`endif

   // Eligibility and grant: a port whose ack is high this cycle is still
   // holding its just-finished request, so it must not be granted again.
   always_comb begin
      d_elig  = d_req & ~d_ack;
      if_elig = if_req & ~if_ack;
`ifdef ARB_FETCH_BUF_EN
      buf_hit = if_elig & buf_valid & (if_addr == buf_addr);
`else
      buf_hit = 1'b0;
`endif
      if_to_mem = if_elig & ~buf_hit;
      // Data wins a tie unless it won the previous one, so fetch never starves.
      grant_d = (state == IDLE) & d_elig &
                (~if_to_mem | (last_grant != GRANT_DATA));
      grant_i = (state == IDLE) & if_to_mem & ~grant_d;
   end

   // Next-state and next-output computation; every output is registered.
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      last_grant_nx = last_grant;
      if_rdata_nx   = if_rdata;
      d_rdata_nx    = d_rdata;
      if_ack_nx     = 1'b0;
      d_ack_nx      = 1'b0;
      mem_en_nx     = 1'b0;
      mem_we_nx     = mem_we;
      mem_addr_nx   = mem_addr;
      mem_wdata_nx  = mem_wdata;
`ifdef ARB_FETCH_BUF_EN
      buf_valid_nx  = buf_valid;
      buf_addr_nx   = buf_addr;
      buf_data_nx   = buf_data;
`endif
      case (state)
         IDLE: begin
`ifdef ARB_FETCH_BUF_EN
            if (buf_hit) begin
               if_ack_nx   = 1'b1;
               if_rdata_nx = buf_data;
            end
`endif
            if (grant_d) begin
               state_nx      = DATA;
               cnt_nx        = LAT_LOAD;
               last_grant_nx = GRANT_DATA;
               mem_en_nx     = 1'b1;
               mem_we_nx     = d_we;
               mem_addr_nx   = d_addr;
               mem_wdata_nx  = d_wdata;
`ifdef ARB_FETCH_BUF_EN
               // A write to the buffered address makes the copy stale.
               if (d_we && (d_addr == buf_addr))
                  buf_valid_nx = 1'b0;
`endif
            end else if (grant_i) begin
               state_nx      = INST;
               cnt_nx        = LAT_LOAD;
               last_grant_nx = GRANT_INST;
               mem_en_nx     = 1'b1;
               mem_we_nx     = 1'b0;
               mem_addr_nx   = if_addr;
            end
         end
         DATA, INST: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nx = IDLE;
               if (state == DATA) begin
                  d_ack_nx = 1'b1;
                  // mem_we is held through the access, so it still tells
                  // whether this was a read.
                  if (!mem_we)
                     d_rdata_nx = mem_rdata;
               end else begin
                  if_ack_nx   = 1'b1;
                  if_rdata_nx = mem_rdata;
`ifdef ARB_FETCH_BUF_EN
                  buf_valid_nx = 1'b1;
                  buf_addr_nx  = mem_addr;
                  buf_data_nx  = mem_rdata;
`endif
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   // State and output registers; reset abandons any outstanding access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         last_grant <= GRANT_INST;
         if_rdata   <= '0;
         if_ack     <= 1'b0;
         d_rdata    <= '0;
         d_ack      <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
`ifdef ARB_FETCH_BUF_EN
         buf_valid  <= 1'b0;
         buf_addr   <= '0;
         buf_data   <= '0;
`endif
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         last_grant <= last_grant_nx;
         if_rdata   <= if_rdata_nx;
         if_ack     <= if_ack_nx;
         d_rdata    <= d_rdata_nx;
         d_ack      <= d_ack_nx;
         mem_en     <= mem_en_nx;
         mem_we     <= mem_we_nx;
         mem_addr   <= mem_addr_nx;
         mem_wdata  <= mem_wdata_nx;
         busy       <= busy_nx;
`ifdef ARB_FETCH_BUF_EN
         buf_valid  <= buf_valid_nx;
         buf_addr   <= buf_addr_nx;
         buf_data   <= buf_data_nx;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_unified_mem_arbiter
//  Purpose  : Scoreboard bench for unified_mem_arbiter: expected memory
//             accesses and acks (with their cycle numbers) are queued when
//             stimulus is driven and compared when the DUT produces them.
//             Also exercises ARB_FETCH_BUF_EN when that macro is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = 16'h0;
   logic [15:0] if_rdata;
   logic        if_ack;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_addr = 16'h0;
   logic [15:0] d_wdata = 16'h0;
   logic [15:0] d_rdata;
   logic        d_ack;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0;
   logic        busy;

   unified_mem_arbiter #(.LATENCY(LAT), .AW(16), .DW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; int cy; } mem_exp_t;
   typedef struct { logic [15:0] data; int cy; } ack_exp_t;

   mem_exp_t mem_q[$];
   ack_exp_t if_q[$];
   ack_exp_t d_q[$];
   mem_exp_t mon_m;
   ack_exp_t mon_a;

   logic [15:0] ref_mem [0:255];
   logic [15:0] mdl_mem [0:255];
   logic [15:0] exp_drd = 16'h0;

   // Memory model: data appears exactly when it must be sampled; garbage before.
   logic       pend = 1'b0;
   int         rem = 0;
   logic [7:0] pend_addr = 8'h0;
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         pend = 1'b0;
      end else if (mem_en) begin
         if (mem_we) mdl_mem[mem_addr[7:0]] = mem_wdata;
         pend_addr = mem_addr[7:0];
         rem       = LAT - 1;
         pend      = 1'b1;
         mem_rdata = 16'hE0E0;
      end else if (pend) begin
         rem = rem - 1;
      end
      if (pend && rem == 0) begin
         mem_rdata = mdl_mem[pend_addr];
         pend      = 1'b0;
      end
   end

   // Monitor: every memory access and ack must match the head of its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en) begin
            if (mem_q.size() == 0) check_val("mem_en_unexpected", mem_en, 0);
            else begin
               mon_m = mem_q.pop_front();
               check_val("mem_we", mem_we, mon_m.we);
               check_val("mem_addr", mem_addr, mon_m.addr);
               if (mon_m.we) check_val("mem_wdata", mem_wdata, mon_m.wdata);
               check_val("mem_en_cycle", cyc, mon_m.cy);
            end
         end
         if (if_ack) begin
            if (if_q.size() == 0) check_val("if_ack_unexpected", if_ack, 0);
            else begin
               mon_a = if_q.pop_front();
               check_val("if_rdata", if_rdata, mon_a.data);
               check_val("if_ack_cycle", cyc, mon_a.cy);
            end
         end
         if (d_ack) begin
            if (d_q.size() == 0) check_val("d_ack_unexpected", d_ack, 0);
            else begin
               mon_a = d_q.pop_front();
               check_val("d_rdata", d_rdata, mon_a.data);
               check_val("d_ack_cycle", cyc, mon_a.cy);
            end
         end
      end
   end

   task automatic goto_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Requests are held through the ack cycle and dropped one cycle later.
   task automatic do_fetch(input logic [15:0] a);
      int k;
      k = cyc + 1;
      if_req = 1'b1; if_addr = a;
      mem_q.push_back('{1'b0, a, 16'h0, k});
      if_q.push_back('{ref_mem[a[7:0]], k + LAT});
      goto_cyc(k + LAT + 1);
      if_req = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] a);
      int k;
      k = cyc + 1;
      d_req = 1'b1; d_we = 1'b0; d_addr = a;
      mem_q.push_back('{1'b0, a, 16'h0, k});
      exp_drd = ref_mem[a[7:0]];
      d_q.push_back('{exp_drd, k + LAT});
      goto_cyc(k + LAT + 1);
      d_req = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] w);
      int k;
      k = cyc + 1;
      d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = w;
      mem_q.push_back('{1'b1, a, w, k});
      d_q.push_back('{exp_drd, k + LAT});
      ref_mem[a[7:0]] = w;
      goto_cyc(k + 1);
      d_wdata = ~w; d_addr = a ^ 16'h0001;   // changes after grant are ignored
      goto_cyc(k + LAT + 1);
      d_req = 1'b0; d_we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c, k, busy_n;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 16'(i * 16'h0111 + 16'h0300);
      end
      ref_mem[8'h10] = 16'hA5A5;
      ref_mem[8'h51] = 16'h1234;
      for (int i = 0; i < 256; i++) mdl_mem[i] = ref_mem[i];

      // Reset state
      repeat (2) @(negedge clk);
      check_val("reset_wide_outs", {if_rdata, d_rdata, mem_addr, mem_wdata}, 64'h0);
      check_val("reset_bit_outs", {if_ack, d_ack, mem_en, mem_we, busy}, 64'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single fetch, busy for LAT cycles
      c = cyc; k = c + 1;
      if_req = 1'b1; if_addr = 16'h0010;
      mem_q.push_back('{1'b0, 16'h0010, 16'h0, k});
      if_q.push_back('{ref_mem[8'h10], k + LAT});
      busy_n = 0;
      repeat (LAT + 2) begin
         @(negedge clk);
         busy_n += int'(busy);
      end
      if_req = 1'b0;
      check_val("t1_busy_cycles", busy_n, LAT);

      // 2: simultaneous data read and fetch -> data first
      c = cyc; k = c + 1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
      if_req = 1'b1; if_addr = 16'h0011;
      mem_q.push_back('{1'b0, 16'h0040, 16'h0, k});
      mem_q.push_back('{1'b0, 16'h0011, 16'h0, k + LAT + 1});
      exp_drd = ref_mem[8'h40];
      d_q.push_back('{exp_drd, k + LAT});
      if_q.push_back('{ref_mem[8'h11], k + 2 * LAT + 1});
      goto_cyc(k + LAT + 1); d_req = 1'b0;
      goto_cyc(k + 2 * LAT + 2); if_req = 1'b0;

      // 3: both held -> D, I, D, I; address changes after grant ignored
      c = cyc; k = c + 1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
      if_req = 1'b1; if_addr = 16'h0060;
      mem_q.push_back('{1'b0, 16'h0050, 16'h0, k});
      mem_q.push_back('{1'b0, 16'h0060, 16'h0, k + (LAT + 1)});
      mem_q.push_back('{1'b0, 16'h0051, 16'h0, k + 2 * (LAT + 1)});
      mem_q.push_back('{1'b0, 16'h0061, 16'h0, k + 3 * (LAT + 1)});
      d_q.push_back('{ref_mem[8'h50], k + LAT});
      if_q.push_back('{ref_mem[8'h60], k + LAT + (LAT + 1)});
      d_q.push_back('{ref_mem[8'h51], k + LAT + 2 * (LAT + 1)});
      if_q.push_back('{ref_mem[8'h61], k + LAT + 3 * (LAT + 1)});
      exp_drd = ref_mem[8'h51];
      goto_cyc(k + 1);               d_addr = 16'h0051;
      goto_cyc(k + (LAT + 1) + 1);   if_addr = 16'h0061;
      goto_cyc(k + LAT + 3 * (LAT + 1)); d_req = 1'b0;
      goto_cyc(k + 4 * (LAT + 1));   if_req = 1'b0;

      // 4: write leaves d_rdata at its previous value, then read back
      do_write(16'h0020, 16'hBEEF);
      check_val("t4_d_rdata_hold", d_rdata, 16'h1234);
      do_read(16'h0020);

      // 5: reset in the 2nd cycle of a data access
      c = cyc; k = c + 1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
      mem_q.push_back('{1'b0, 16'h0030, 16'h0, k});
      goto_cyc(k + 1);
      rst_n = 1'b0; d_req = 1'b0;
      #1;
      check_val("t5_rst_wide_outs", {if_rdata, d_rdata, mem_addr, mem_wdata}, 64'h0);
      check_val("t5_rst_bit_outs", {if_ack, d_ack, mem_en, mem_we, busy}, 64'h0);
      exp_drd = 16'h0;
      goto_cyc(k + 3); rst_n = 1'b1;
      goto_cyc(k + LAT + 8);
      check_val("t5_busy_after", busy, 0);
      do_fetch(16'h0070);
      do_read(16'h0020);

      // 6: fetch buffer
      do_fetch(16'h0080);
`ifdef ARB_FETCH_BUF_EN
      c = cyc; k = c + 1;
      if_req = 1'b1; if_addr = 16'h0080;
      if_q.push_back('{ref_mem[8'h80], k});
      goto_cyc(k);
      check_val("t6_hit_busy", busy, 0);
      goto_cyc(k + 1); if_req = 1'b0;
`else
      do_fetch(16'h0080);
`endif
      do_write(16'h0080, 16'h7777);
      do_fetch(16'h0080);

      repeat (LAT + 3) @(negedge clk);
      check_val("mem_q_left", mem_q.size(), 0);
      check_val("if_q_left", if_q.size(), 0);
      check_val("d_q_left", d_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
